// File: rtl/memory_arbiter.sv
// Shares one single-ported RAM between the instruction-fetch and data ports.
// Optional: define MEMORY_ARBITER_RR_EN for round-robin on contention (default: data beats instruction).
module memory_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] iload,
    output logic              iwait,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic [DATA_W-1:0] dload,
    output logic              dwait,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              arb_err
);

    localparam int unsigned CNT_W      = $clog2(TIMEOUT + 1);
    localparam logic [1:0]  RAM_ACCESS = 2'b10;
    localparam logic [1:0]  RAM_ERROR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_IGNT = 2'b01,
        ST_DGNT = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic              ren_q, ren_d;
    logic              wen_q, wen_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] store_q, store_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic d_req;
    logic pick_d;
    logic in_grant;
    logic access;
    logic timeout_hit;
    logic abort;

    assign d_req       = dREN | dWEN;
    assign in_grant    = (state_q != ST_IDLE);
    assign access      = (ramstate == RAM_ACCESS);
    // Last grant cycle is the one in which the count would reach TIMEOUT.
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign abort       = in_grant & ~access & ((ramstate == RAM_ERROR) | timeout_hit);

`ifdef MEMORY_ARBITER_RR_EN
    logic last_d_q, last_d_d;

    // Remembers which port completed most recently (1 = data); aborts do not count.
    assign last_d_d = (in_grant & access) ? (state_q == ST_DGNT) : last_d_q;
    assign pick_d   = d_req & (~iREN | ~last_d_q);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end
`else
    assign pick_d = d_req;
`endif

    // Next-state and registered RAM-side outputs.
    always_comb begin
        state_d = state_q;
        ren_d   = ren_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        store_d = store_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (pick_d) begin
                    state_d = ST_DGNT;
                    ren_d   = ~dWEN;
                    wen_d   = dWEN;
                    addr_d  = daddr;
                    store_d = dstore;
                end else if (iREN) begin
                    state_d = ST_IGNT;
                    ren_d   = 1'b1;
                    wen_d   = 1'b0;
                    addr_d  = iaddr;
                end
            end
            ST_IGNT, ST_DGNT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (access || abort) begin
                    state_d = ST_IDLE;
                    ren_d   = 1'b0;
                    wen_d   = 1'b0;
                    cnt_d   = '0;
                    err_d   = abort;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ren_d   = 1'b0;
                wen_d   = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            store_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ramREN   = ren_q;
    assign ramWEN   = wen_q;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;
    assign arb_err  = err_q;

    // Port-side wait/load follow RAM completion in the same cycle.
    assign iload = ramload;
    assign dload = ramload;
    assign iwait = iREN & ~((state_q == ST_IGNT) & access);
    assign dwait = d_req & ~((state_q == ST_DGNT) & access);

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbitration rules.
module tb_memory_arbiter;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 4;
    localparam logic [1:0]  RS_FREE   = 2'b00;
    localparam logic [1:0]  RS_BUSY   = 2'b01;
    localparam logic [1:0]  RS_ACCESS = 2'b10;
    localparam logic [1:0]  RS_ERROR  = 2'b11;
`ifdef MEMORY_ARBITER_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              nRST;
    logic              iREN, dREN, dWEN;
    logic [ADDR_W-1:0] iaddr, daddr, ramaddr;
    logic [DATA_W-1:0] dstore, iload, dload, ramstore, ramload;
    logic              iwait, dwait, ramREN, ramWEN, arb_err;
    logic [1:0]        ramstate;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    memory_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .arb_err(arb_err)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
        ramstate = RS_FREE;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        clear_inputs();
        #3;
        n_checks++; if (ramREN !== 1'b0) begin n_fail++; $display("FAIL reset_ramREN got=%b exp=0", ramREN); end
        n_checks++; if (ramWEN !== 1'b0) begin n_fail++; $display("FAIL reset_ramWEN got=%b exp=0", ramWEN); end
        n_checks++; if (iwait !== 1'b0) begin n_fail++; $display("FAIL reset_iwait got=%b exp=0", iwait); end
        n_checks++; if (dwait !== 1'b0) begin n_fail++; $display("FAIL reset_dwait got=%b exp=0", dwait); end
        n_checks++; if (arb_err !== 1'b0) begin n_fail++; $display("FAIL reset_arb_err got=%b exp=0", arb_err); end
        n_checks++; if (ramaddr !== '0) begin n_fail++; $display("FAIL reset_ramaddr got=%h exp=0", ramaddr); end
        n_checks++; if (ramstore !== '0) begin n_fail++; $display("FAIL reset_ramstore got=%h exp=0", ramstore); end
        tick();
        tick();
        nRST = 1'b1;
    endtask

    task automatic test_ifetch();
        tick();
        iREN = 1'b1; iaddr = 32'h40; ramstate = RS_FREE;
        #1;
        n_checks++; if (iwait !== 1'b1) begin n_fail++; $display("FAIL ifetch_idle_iwait got=%b exp=1", iwait); end
        n_checks++; if (ramREN !== 1'b0) begin n_fail++; $display("FAIL ifetch_idle_ramREN got=%b exp=0", ramREN); end
        tick();
        n_checks++; if (ramREN !== 1'b1) begin n_fail++; $display("FAIL ifetch_ramREN got=%b exp=1", ramREN); end
        n_checks++; if (ramaddr !== 32'h40) begin n_fail++; $display("FAIL ifetch_ramaddr got=%h exp=40", ramaddr); end
        ramstate = RS_BUSY;
        #1;
        n_checks++; if (iwait !== 1'b1) begin n_fail++; $display("FAIL ifetch_busy_iwait got=%b exp=1", iwait); end
        tick();
        ramstate = RS_ACCESS; ramload = 32'h2402000A;
        #1;
        n_checks++; if (iwait !== 1'b0) begin n_fail++; $display("FAIL ifetch_access_iwait got=%b exp=0", iwait); end
        n_checks++; if (iload !== 32'h2402000A) begin n_fail++; $display("FAIL ifetch_iload got=%h exp=2402000a", iload); end
        tick();
        n_checks++; if (ramREN !== 1'b0) begin n_fail++; $display("FAIL ifetch_done_ramREN got=%b exp=0", ramREN); end
        n_checks++; if (iwait !== 1'b1) begin n_fail++; $display("FAIL ifetch_after_iwait got=%b exp=1", iwait); end
        iREN = 1'b0; ramstate = RS_FREE;
        #1;
        n_checks++; if (iwait !== 1'b0) begin n_fail++; $display("FAIL ifetch_noreq_iwait got=%b exp=0", iwait); end
    endtask

    task automatic test_contention();
        tick();
        iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; daddr = 32'h80; dstore = 32'hDEADBEEF;
        #1;
        n_checks++; if (dwait !== 1'b1) begin n_fail++; $display("FAIL cont_idle_dwait got=%b exp=1", dwait); end
        tick();
        n_checks++; if (ramWEN !== 1'b1) begin n_fail++; $display("FAIL cont_ramWEN got=%b exp=1", ramWEN); end
        n_checks++; if (ramREN !== 1'b0) begin n_fail++; $display("FAIL cont_ramREN got=%b exp=0", ramREN); end
        n_checks++; if (ramaddr !== 32'h80) begin n_fail++; $display("FAIL cont_ramaddr got=%h exp=80", ramaddr); end
        n_checks++; if (ramstore !== 32'hDEADBEEF) begin n_fail++; $display("FAIL cont_ramstore got=%h exp=deadbeef", ramstore); end
        ramstate = RS_BUSY;
        #1;
        n_checks++; if (iwait !== 1'b1) begin n_fail++; $display("FAIL cont_busy_iwait got=%b exp=1", iwait); end
        tick();
        ramstate = RS_ACCESS;
        #1;
        n_checks++; if (dwait !== 1'b0) begin n_fail++; $display("FAIL cont_access_dwait got=%b exp=0", dwait); end
        n_checks++; if (iwait !== 1'b1) begin n_fail++; $display("FAIL cont_access_iwait got=%b exp=1", iwait); end
        tick();
        dWEN = 1'b0; ramstate = RS_FREE;
        tick();
        n_checks++; if (ramREN !== 1'b1) begin n_fail++; $display("FAIL cont_igrant_ramREN got=%b exp=1", ramREN); end
        n_checks++; if (ramaddr !== 32'h44) begin n_fail++; $display("FAIL cont_igrant_ramaddr got=%h exp=44", ramaddr); end
        ramstate = RS_ACCESS; ramload = 32'h1234;
        #1;
        n_checks++; if (iwait !== 1'b0) begin n_fail++; $display("FAIL cont_igrant_iwait got=%b exp=0", iwait); end
        tick();
        iREN = 1'b0; ramstate = RS_FREE;
    endtask

    task automatic test_priority();
        bit last_was_d = 1'b0;
        bit want_d;
        iREN = 1'b1; dREN = 1'b1; iaddr = 32'h100; daddr = 32'h200;
        for (int k = 0; k < 4; k++) begin
            tick();
            want_d = !RR || !last_was_d;
            n_checks++; if (ramaddr !== (want_d ? 32'h200 : 32'h100)) begin n_fail++; $display("FAIL prio_grant%0d got=%h exp=%h", k, ramaddr, want_d ? 32'h200 : 32'h100); end
            ramstate = RS_ACCESS;
            #1;
            n_checks++; if (iwait !== want_d) begin n_fail++; $display("FAIL prio_iwait%0d got=%b exp=%b", k, iwait, want_d); end
            n_checks++; if (dwait !== !want_d) begin n_fail++; $display("FAIL prio_dwait%0d got=%b exp=%b", k, dwait, !want_d); end
            last_was_d = want_d;
            tick();
            ramstate = RS_FREE;
        end
        iREN = 1'b0; dREN = 1'b0;
    endtask

    task automatic test_error();
        tick();
        dREN = 1'b1; daddr = 32'h300;
        tick();
        n_checks++; if (ramREN !== 1'b1) begin n_fail++; $display("FAIL err_grant_ramREN got=%b exp=1", ramREN); end
        ramstate = RS_ERROR;
        #1;
        n_checks++; if (dwait !== 1'b1) begin n_fail++; $display("FAIL err_dwait got=%b exp=1", dwait); end
        tick();
        n_checks++; if (arb_err !== 1'b1) begin n_fail++; $display("FAIL err_pulse got=%b exp=1", arb_err); end
        n_checks++; if (ramREN !== 1'b0) begin n_fail++; $display("FAIL err_drop_ramREN got=%b exp=0", ramREN); end
        ramstate = RS_FREE;
        #1;
        n_checks++; if (dwait !== 1'b1) begin n_fail++; $display("FAIL err_idle_dwait got=%b exp=1", dwait); end
        tick();
        n_checks++; if (arb_err !== 1'b0) begin n_fail++; $display("FAIL err_pulse_len got=%b exp=0", arb_err); end
        n_checks++; if (ramREN !== 1'b1) begin n_fail++; $display("FAIL err_regrant got=%b exp=1", ramREN); end
        ramstate = RS_ACCESS;
        #1;
        n_checks++; if (dwait !== 1'b0) begin n_fail++; $display("FAIL err_retry_dwait got=%b exp=0", dwait); end
        tick();
        dREN = 1'b0; ramstate = RS_FREE;
    endtask

    task automatic test_timeout();
        int grants = 0;
        bit got_err = 1'b0;
        tick();
        iREN = 1'b1; iaddr = 32'h500; ramstate = RS_BUSY;
        for (int c = 0; c < 12 && !got_err; c++) begin
            tick();
            if (arb_err === 1'b1) got_err = 1'b1;
            else if (ramREN === 1'b1) grants++;
        end
        n_checks++; if (got_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err got=%b exp=1", got_err); end
        n_checks++; if (grants != TIMEOUT) begin n_fail++; $display("FAIL timeout_cycles got=%0d exp=%0d", grants, TIMEOUT); end
        n_checks++; if (ramREN !== 1'b0) begin n_fail++; $display("FAIL timeout_ramREN got=%b exp=0", ramREN); end
        n_checks++; if (iwait !== 1'b1) begin n_fail++; $display("FAIL timeout_iwait got=%b exp=1", iwait); end
        iREN = 1'b0; ramstate = RS_FREE;
    endtask

    task automatic test_reset_mid_grant();
        tick();
        dWEN = 1'b1; daddr = 32'h600; dstore = 32'h55; ramstate = RS_BUSY;
        tick();
        n_checks++; if (ramWEN !== 1'b1) begin n_fail++; $display("FAIL rstmid_ramWEN_pre got=%b exp=1", ramWEN); end
        #2;
        nRST = 1'b0;
        #1;
        n_checks++; if (ramWEN !== 1'b0) begin n_fail++; $display("FAIL rstmid_ramWEN got=%b exp=0", ramWEN); end
        n_checks++; if (ramaddr !== '0) begin n_fail++; $display("FAIL rstmid_ramaddr got=%h exp=0", ramaddr); end
        clear_inputs();
        tick();
        nRST = 1'b1;
    endtask

    task automatic test_random();
        int          m_owner = 0;
        int          m_age   = 0;
        bit          m_wr    = 1'b0;
        bit          m_err   = 1'b0;
        bit          m_last_d = 1'b0;
        logic [31:0] m_addr  = '0;
        logic [31:0] m_store = '0;
        int          r;
        bit          dreq;
        nRST = 1'b0;
        clear_inputs();
        tick();
        nRST = 1'b1;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            tick();
            n_checks++; if (ramREN !== (m_owner != 0 && !m_wr)) begin n_fail++; $display("FAIL rnd_ramREN cyc=%0d got=%b exp=%b", cyc, ramREN, m_owner != 0 && !m_wr); end
            n_checks++; if (ramWEN !== (m_owner != 0 && m_wr)) begin n_fail++; $display("FAIL rnd_ramWEN cyc=%0d got=%b exp=%b", cyc, ramWEN, m_owner != 0 && m_wr); end
            n_checks++; if (ramaddr !== m_addr) begin n_fail++; $display("FAIL rnd_ramaddr cyc=%0d got=%h exp=%h", cyc, ramaddr, m_addr); end
            n_checks++; if (ramstore !== m_store) begin n_fail++; $display("FAIL rnd_ramstore cyc=%0d got=%h exp=%h", cyc, ramstore, m_store); end
            n_checks++; if (arb_err !== m_err) begin n_fail++; $display("FAIL rnd_arb_err cyc=%0d got=%b exp=%b", cyc, arb_err, m_err); end
            iREN = 1'($urandom_range(0, 1));
            dREN = ($urandom_range(0, 2) == 0);
            dWEN = ($urandom_range(0, 2) == 0);
            iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
            r = $urandom_range(0, 9);
            ramstate = (r < 4) ? RS_BUSY : (r < 7) ? RS_ACCESS : (r < 8) ? RS_ERROR : RS_FREE;
            #1;
            dreq = dREN || dWEN;
            n_checks++; if (iwait !== (iREN && !(m_owner == 1 && ramstate == RS_ACCESS))) begin n_fail++; $display("FAIL rnd_iwait cyc=%0d got=%b", cyc, iwait); end
            n_checks++; if (dwait !== (dreq && !(m_owner == 2 && ramstate == RS_ACCESS))) begin n_fail++; $display("FAIL rnd_dwait cyc=%0d got=%b", cyc, dwait); end
            n_checks++; if (iload !== ramload || dload !== ramload) begin n_fail++; $display("FAIL rnd_load cyc=%0d got=%h/%h exp=%h", cyc, iload, dload, ramload); end
            // Advance the transaction model to the next edge.
            m_err = 1'b0;
            if (m_owner == 0) begin
                m_age = 0;
                if (dreq && (!RR || !iREN || !m_last_d)) begin
                    m_owner = 2; m_addr = daddr; m_store = dstore; m_wr = dWEN;
                end else if (iREN) begin
                    m_owner = 1; m_addr = iaddr; m_wr = 1'b0;
                end
            end else if (ramstate == RS_ACCESS) begin
                m_last_d = (m_owner == 2);
                m_owner = 0; m_wr = 1'b0;
            end else if (ramstate == RS_ERROR || m_age + 1 == int'(TIMEOUT)) begin
                m_owner = 0; m_wr = 1'b0; m_err = 1'b1;
            end else begin
                m_age++;
            end
        end
        clear_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ifetch();
        test_contention();
        test_priority();
        test_error();
        test_timeout();
        test_reset_mid_grant();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
